// File: rtl/audio_frame_pkg.sv
// Shared types and default geometry for the audio frame ping-pong buffer.
// Bank lifecycle: FREE -> QUEUED -> BUSY -> READY -> FREE.
package audio_frame_pkg;

  localparam int DEF_LINE_W      = 512;
  localparam int DEF_FRAME_LINES = 64;
  localparam int DEF_NUM_BANKS   = 2;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    QUEUED = 2'd1,
    BUSY   = 2'd2,
    READY  = 2'd3
  } bank_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } core_fsm_e;

endpackage

// File: rtl/afs_bank_ram.sv
// Banked line storage addressed as {bank, line index}: one host write port,
// one core read/write port and one host read port, all reads registered.
module afs_bank_ram
  import audio_frame_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int AW     = 7
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [AW-1:0]     host_waddr,
  input  logic [LINE_W-1:0] host_wdata,
  input  logic [AW-1:0]     host_raddr,
  output logic [LINE_W-1:0] host_rdata,
  input  logic              core_we,
  input  logic [AW-1:0]     core_addr,
  input  logic [LINE_W-1:0] core_wdata,
  output logic [LINE_W-1:0] core_rdata
);

  logic [LINE_W-1:0] mem [2**AW];

  // NOTE: the array has no reset; a frame is always written before it is consumed.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_waddr] <= host_wdata;
    if (core_we) mem[core_addr]  <= core_wdata;
  end

  // NOTE: non-blocking assignments make a same-cycle core write return the pre-edge line.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata <= '0;
      core_rdata <= '0;
    end else begin
      host_rdata <= mem[host_raddr];
      core_rdata <= mem[core_addr];
    end
  end

endmodule

// File: rtl/audio_frame_pingpong.sv
// Multi-bank frame buffer between the host line bus and the spectral core.
// Optional statistics counters are enabled with `define AFS_STATS_EN.
module audio_frame_pingpong
  import audio_frame_pkg::*;
#(
  parameter int  LINE_W      = DEF_LINE_W,
  parameter int  FRAME_LINES = DEF_FRAME_LINES,
  parameter int  NUM_BANKS   = DEF_NUM_BANKS,
  localparam int IDX_W       = $clog2(FRAME_LINES),
  localparam int BK_W        = $clog2(NUM_BANKS)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [IDX_W-1:0]  host_wr_idx,
  input  logic [LINE_W-1:0] host_wr_data,
  input  logic              host_commit,
  output logic              host_full,
  input  logic [IDX_W-1:0]  host_rd_idx,
  output logic [LINE_W-1:0] host_rd_data,
  output logic              host_rd_valid,
  input  logic              host_release,
  output logic              core_start,
  input  logic              core_done,
  input  logic [IDX_W-1:0]  core_addr,
  output logic [LINE_W-1:0] core_rd_data,
  input  logic              core_wr_en,
  input  logic [LINE_W-1:0] core_wr_data,
  output logic              err_pulse,
  output logic [31:0]       frames_done,
  output logic [15:0]       reject_cnt
);

  bank_state_e     bank_st [NUM_BANKS];
  logic [BK_W-1:0] wr_ptr, proc_ptr, rd_ptr;
  core_fsm_e       core_state, core_next;
  logic            start_go, done_ok;
  logic            wr_ok, commit_ok, rel_ok, reject;

  assign host_full     = (bank_st[wr_ptr] != FREE);
  assign host_rd_valid = (bank_st[rd_ptr] == READY);

  assign wr_ok     = host_wr_en && !host_full;
  assign commit_ok = host_commit && !host_full;
  assign rel_ok    = host_release && host_rd_valid;
  assign reject    = (host_full && (host_wr_en || host_commit))
                  || (core_done && (core_state == IDLE))
                  || (host_release && !host_rd_valid);

  // Fill, processing and drain banks are disjoint, so the three ports never collide.
  afs_bank_ram #(
    .LINE_W (LINE_W),
    .AW     (BK_W + IDX_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .host_we    (wr_ok),
    .host_waddr ({wr_ptr, host_wr_idx}),
    .host_wdata (host_wr_data),
    .host_raddr ({rd_ptr, host_rd_idx}),
    .host_rdata (host_rd_data),
    .core_we    (core_wr_en && (core_state == RUN)),
    .core_addr  ({proc_ptr, core_addr}),
    .core_wdata (core_wr_data),
    .core_rdata (core_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) core_state <= IDLE;
    else     core_state <= core_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    core_next = core_state;
    start_go  = 1'b0;
    done_ok   = 1'b0;
    case (core_state)
      IDLE: if (bank_st[proc_ptr] == QUEUED) begin
        start_go  = 1'b1;
        core_next = RUN;
      end
      RUN: if (core_done) begin
        done_ok   = 1'b1;
        core_next = IDLE;
      end
      default: core_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_st[b] <= FREE;
      wr_ptr     <= '0;
      proc_ptr   <= '0;
      rd_ptr     <= '0;
      core_start <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      // Each event targets a bank in a different state, so at most one fires per bank.
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (commit_ok && wr_ptr == BK_W'(b))        bank_st[b] <= QUEUED;
        else if (start_go && proc_ptr == BK_W'(b))  bank_st[b] <= BUSY;
        else if (done_ok && proc_ptr == BK_W'(b))   bank_st[b] <= READY;
        else if (rel_ok && rd_ptr == BK_W'(b))      bank_st[b] <= FREE;
      end
      if (commit_ok) wr_ptr   <= wr_ptr + 1'b1;
      if (done_ok)   proc_ptr <= proc_ptr + 1'b1;
      if (rel_ok)    rd_ptr   <= rd_ptr + 1'b1;
      core_start <= start_go;
      err_pulse  <= reject;
    end
  end

`ifdef AFS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_done <= '0;
      reject_cnt  <= '0;
    end else begin
      if (done_ok) frames_done <= frames_done + 32'd1;
      if (reject && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
    end
  end
`else
  assign frames_done = '0;
  assign reject_cnt  = '0;
`endif

endmodule

// File: tb/tb_audio_frame_pingpong.sv
// Bench for audio_frame_pingpong: a 2-bank instance for directed scenarios and a
// 4-bank instance for randomized back-to-back streaming against a frame-level model.
module tb_audio_frame_pingpong;

`ifdef AFS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int NFRAMES = 232;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_wr_en;
  logic [5:0]   host_wr_idx;
  logic [511:0] host_wr_data;
  logic         host_commit;
  logic [5:0]   host_rd_idx;
  logic         host_release;
  logic         core_done;
  logic [5:0]   core_addr;
  logic         core_wr_en;
  logic [511:0] core_wr_data;

  logic         a_full, a_valid, a_start, a_err;
  logic [511:0] a_rd_data, a_core_rd;
  logic [31:0]  a_frames;
  logic [15:0]  a_rej;
  logic         b_full, b_valid, b_start, b_err;
  logic [511:0] b_rd_data, b_core_rd;
  logic [31:0]  b_frames;
  logic [15:0]  b_rej;

  int errors = 0;
  int checks = 0;
  bit abort;
  int drained;
  logic [31:0] seeds [$];

  always #5 clk = ~clk;

  audio_frame_pingpong #(.LINE_W(512), .FRAME_LINES(64), .NUM_BANKS(2)) dut2 (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx), .host_wr_data(host_wr_data),
    .host_commit(host_commit), .host_full(a_full),
    .host_rd_idx(host_rd_idx), .host_rd_data(a_rd_data), .host_rd_valid(a_valid),
    .host_release(host_release), .core_start(a_start), .core_done(core_done),
    .core_addr(core_addr), .core_rd_data(a_core_rd), .core_wr_en(core_wr_en),
    .core_wr_data(core_wr_data), .err_pulse(a_err), .frames_done(a_frames),
    .reject_cnt(a_rej)
  );

  audio_frame_pingpong #(.LINE_W(512), .FRAME_LINES(64), .NUM_BANKS(4)) dut4 (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx), .host_wr_data(host_wr_data),
    .host_commit(host_commit), .host_full(b_full),
    .host_rd_idx(host_rd_idx), .host_rd_data(b_rd_data), .host_rd_valid(b_valid),
    .host_release(host_release), .core_start(b_start), .core_done(core_done),
    .core_addr(core_addr), .core_rd_data(b_core_rd), .core_wr_en(core_wr_en),
    .core_wr_data(core_wr_data), .err_pulse(b_err), .frames_done(b_frames),
    .reject_cnt(b_rej)
  );

  function automatic logic [511:0] line_data(input logic [31:0] seed, input int i);
    logic [511:0] v;
    for (int k = 0; k < 16; k++)
      v[k*32 +: 32] = seed ^ (32'(i) * 32'h9E3779B9) ^ (32'(k) << 24);
    return v;
  endfunction

  function automatic logic [511:0] rep16(input logic [15:0] w);
    return {32{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_wr_en = 0; host_wr_idx = '0; host_wr_data = '0; host_commit = 0;
    host_rd_idx = '0; host_release = 0; core_done = 0; core_addr = '0;
    core_wr_en = 0; core_wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // mode 0: separate commit cycle, 1: commit with last line, 2: no commit
  task automatic fill_frame(input logic [15:0] base, input int mode);
    for (int i = 0; i < 64; i++) begin
      host_wr_en   = 1;
      host_wr_idx  = 6'(i);
      host_wr_data = rep16(base + 16'(i));
      host_commit  = (mode == 1 && i == 63);
      step();
    end
    host_wr_en  = 0;
    host_commit = 0;
    if (mode == 0) begin
      host_commit = 1;
      step();
      host_commit = 0;
    end
  endtask

  task automatic core_invert();
    for (int i = 0; i < 64; i++) begin
      core_addr = 6'(i);
      step();
      core_wr_en   = 1;
      core_wr_data = ~a_core_rd;
      step();
      core_wr_en = 0;
    end
  endtask

  task automatic pulse_done();
    core_done = 1;
    step();
    core_done = 0;
  endtask

  task automatic pulse_release();
    host_release = 1;
    step();
    host_release = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    checks++;
    if ({a_full, a_valid, a_start, a_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {a_full, a_valid, a_start, a_err});
    checks++;
    if ({a_frames, a_rej} !== 48'd0)
      $display("FAIL reset_stats: got %h expected 0", {a_frames, a_rej});
    checks++;
    if ({a_rd_data, a_core_rd} !== 1024'd0)
      $display("FAIL reset_rd_data: got nonzero read data expected 0");
    if ({a_full, a_valid, a_start, a_err} !== 4'b0000) errors++;
    if ({a_frames, a_rej} !== 48'd0) errors++;
    if ({a_rd_data, a_core_rd} !== 1024'd0) errors++;
    step();
    rst = 0;
  endtask

  task automatic test_single_frame();
    logic [511:0] exp;
    do_reset();
    fill_frame(16'h0000, 0);
    checks++;
    if (a_start !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", a_start); end
    step();
    checks++;
    if (a_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", a_start); end
    for (int i = 0; i < 64; i++) begin
      core_addr = 6'(i);
      step();
      exp = rep16(16'(i));
      checks++;
      if (a_core_rd !== exp) begin
        errors++;
        $display("FAIL core_rd line %0d: got %h expected %h", i, a_core_rd, exp);
      end
      core_wr_en   = 1;
      core_wr_data = ~a_core_rd;
      step();
      core_wr_en = 0;
    end
    pulse_done();
    checks++;
    if ({a_valid, a_err} !== 2'b10) begin
      errors++; $display("FAIL valid_after_done: got %b expected 10", {a_valid, a_err});
    end
    host_rd_idx = 6'd5;
    step();
    exp = ~rep16(16'd5);
    checks++;
    if (a_rd_data !== exp) begin errors++; $display("FAIL drain_idx5: got %h expected %h", a_rd_data, exp); end
    checks++;
    if (a_frames !== (STATS ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL frames_one: got %0d expected %0d", a_frames, STATS ? 1 : 0);
    end
    pulse_release();
    checks++;
    if ({a_valid, a_err} !== 2'b00) begin
      errors++; $display("FAIL release: got %b expected 00", {a_valid, a_err});
    end
  endtask

  task automatic test_full();
    logic [511:0] exp;
    do_reset();
    fill_frame(16'h0000, 0);
    fill_frame(16'h1000, 0);
    checks++;
    if (a_full !== 1'b1) begin errors++; $display("FAIL full_two_frames: got %b expected 1", a_full); end
    host_wr_en = 1; host_wr_idx = 6'd5; host_wr_data = '1;
    step();
    host_wr_en = 0;
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL err_write_full: got %b expected 1", a_err); end
    checks++;
    if (a_rej !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL reject_cnt_one: got %0d expected %0d", a_rej, STATS ? 1 : 0);
    end
    step();
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL err_width: got %b expected 0", a_err); end
    host_commit = 1;
    step();
    host_commit = 0;
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL err_commit_full: got %b expected 1", a_err); end
    core_invert();
    pulse_done();
    checks++;
    if (a_full !== 1'b1) begin errors++; $display("FAIL full_while_ready: got %b expected 1", a_full); end
    host_rd_idx = 6'd5;
    step();
    exp = ~rep16(16'd5);
    checks++;
    if (a_rd_data !== exp) begin errors++; $display("FAIL dropped_write: got %h expected %h", a_rd_data, exp); end
    pulse_release();
    checks++;
    if (a_full !== 1'b0) begin errors++; $display("FAIL full_after_release: got %b expected 0", a_full); end
  endtask

  task automatic test_back_to_back_commit();
    logic [511:0] exp;
    int n;
    do_reset();
    fill_frame(16'h0100, 0);
    n = 0;
    while (!a_start && n < 8) begin step(); n++; end
    checks++;
    if (a_start !== 1'b1) begin errors++; $display("FAIL start_a: got %b expected 1", a_start); end
    core_invert();
    fill_frame(16'h0200, 2);
    host_commit = 1;
    core_done   = 1;
    step();
    host_commit = 0;
    core_done   = 0;
    checks++;
    if ({a_start, a_valid} !== 2'b01) begin
      errors++; $display("FAIL commit_done_same: got %b expected 01", {a_start, a_valid});
    end
    step();
    checks++;
    if (a_start !== 1'b1) begin errors++; $display("FAIL start_b: got %b expected 1", a_start); end
    core_invert();
    pulse_done();
    host_rd_idx = 6'd7;
    step();
    exp = ~rep16(16'h0107);
    checks++;
    if (a_rd_data !== exp) begin errors++; $display("FAIL drain_a: got %h expected %h", a_rd_data, exp); end
    pulse_release();
    checks++;
    if (a_valid !== 1'b1) begin errors++; $display("FAIL valid_b: got %b expected 1", a_valid); end
    step();
    exp = ~rep16(16'h0207);
    checks++;
    if (a_rd_data !== exp) begin errors++; $display("FAIL drain_b: got %h expected %h", a_rd_data, exp); end
    pulse_release();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL valid_empty: got %b expected 0", a_valid); end
  endtask

  task automatic test_errors();
    do_reset();
    pulse_done();
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL err_done_idle: got %b expected 1", a_err); end
    step();
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", a_err); end
    pulse_release();
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL err_release_empty: got %b expected 1", a_err); end
    checks++;
    if ({a_full, a_valid, a_start} !== 3'b000) begin
      errors++; $display("FAIL state_after_errs: got %b expected 000", {a_full, a_valid, a_start});
    end
    checks++;
    if ({a_frames, a_rej} !== {32'd0, (STATS ? 16'd2 : 16'd0)}) begin
      errors++; $display("FAIL stats_after_errs: got %h expected %h", {a_frames, a_rej},
                         {32'd0, (STATS ? 16'd2 : 16'd0)});
    end
    fill_frame(16'h0300, 1);
    step();
    checks++;
    if (a_start !== 1'b1) begin errors++; $display("FAIL start_after_errs: got %b expected 1", a_start); end
  endtask

  task automatic test_reset_in_run();
    do_reset();
    fill_frame(16'h0400, 0);
    fill_frame(16'h0500, 0);
    core_invert();
    pulse_done();
    step();
    checks++;
    if ({a_full, a_valid, a_start} !== 3'b111) begin
      errors++; $display("FAIL pre_reset: got %b expected 111", {a_full, a_valid, a_start});
    end
    rst = 1;
    step();
    checks++;
    if ({a_full, a_valid, a_start, a_err} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {a_full, a_valid, a_start, a_err});
    end
    checks++;
    if (a_frames !== 32'd0) begin errors++; $display("FAIL mid_reset_frames: got %0d expected 0", a_frames); end
    rst = 0;
  endtask

  task automatic fill4();
    int n;
    logic [31:0] seed;
    for (int f = 0; f < NFRAMES && !abort; f++) begin
      n = 0;
      while (b_full && n < 5000 && !abort) begin step(); n++; end
      if (abort) break;
      checks++;
      if (b_full) begin
        errors++; abort = 1;
        $display("FAIL fill_timeout frame %0d: host_full stuck at %b expected 0", f, b_full);
        break;
      end
      seed = $urandom;
      fill_frame_seed(seed, $urandom_range(0, 1));
      seeds.push_back(seed);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic fill_frame_seed(input logic [31:0] seed, input int with_last);
    for (int i = 0; i < 64; i++) begin
      host_wr_en   = 1;
      host_wr_idx  = 6'(i);
      host_wr_data = line_data(seed, i);
      host_commit  = (with_last == 1 && i == 63);
      step();
    end
    host_wr_en  = 0;
    host_commit = 0;
    if (with_last == 0) begin
      host_commit = 1;
      step();
      host_commit = 0;
    end
  endtask

  task automatic core4();
    int n;
    for (int f = 0; f < NFRAMES && !abort; f++) begin
      n = 0;
      while (!b_start && n < 5000 && !abort) begin step(); n++; end
      if (abort) break;
      checks++;
      if (!b_start) begin
        errors++; abort = 1;
        $display("FAIL core_start_timeout frame %0d: got %b expected 1", f, b_start);
        break;
      end
      for (int i = 0; i < 64; i++) begin
        core_addr = 6'(i);
        step();
        core_wr_en   = 1;
        core_wr_data = ~b_core_rd;
        step();
        core_wr_en = 0;
      end
      repeat ($urandom_range(0, 6)) step();
      pulse_done();
    end
  endtask

  task automatic drain4();
    int n;
    logic [511:0] exp;
    for (int f = 0; f < NFRAMES && !abort; f++) begin
      n = 0;
      while (!b_valid && n < 5000 && !abort) begin step(); n++; end
      if (abort) break;
      checks++;
      if (!b_valid || f >= seeds.size()) begin
        errors++; abort = 1;
        $display("FAIL drain_timeout frame %0d: valid %b expected 1", f, b_valid);
        break;
      end
      for (int i = 0; i < 64; i++) begin
        host_rd_idx = 6'(i);
        step();
        exp = ~line_data(seeds[f], i);
        checks++;
        if (b_rd_data !== exp) begin
          errors++;
          $display("FAIL drain f=%0d l=%0d: got %h expected %h", f, i, b_rd_data, exp);
        end
      end
      repeat ($urandom_range(0, 3)) step();
      pulse_release();
      drained++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    abort   = 0;
    drained = 0;
    seeds.delete();
    fork
      fill4();
      core4();
      drain4();
    join
    checks++;
    if (drained !== NFRAMES) begin
      errors++; $display("FAIL frames_drained: got %0d expected %0d", drained, NFRAMES);
    end
    checks++;
    if (b_frames !== (STATS ? 32'(NFRAMES) : 32'd0)) begin
      errors++; $display("FAIL frames_done: got %0d expected %0d", b_frames, STATS ? NFRAMES : 0);
    end
    checks++;
    if (b_rej !== 16'd0) begin errors++; $display("FAIL reject_cnt_stream: got %0d expected 0", b_rej); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_full();
    test_back_to_back_commit();
    test_errors();
    test_reset_in_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
